// File: rtl/reg_pkg.sv
// Register-file constants, write-back source ids and the address decode helper
// shared by the write-back arbiter and the issue stage.
package reg_pkg;

  localparam int NUM_REGS       = 32;
  localparam int REG_ADDR_W     = 5;
  localparam int REG_FLOAT_BASE = 16;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_FPU = 2'd1,
    WB_LSU = 2'd2
  } wb_src_t;

  // r0 is hard-wired zero, so its decode is all-zero.
  function automatic logic [NUM_REGS-1:0] onehot32(input logic [REG_ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] v;
    v = '0;
    if (addr != '0) v[addr] = 1'b1;
    return v;
  endfunction

  function automatic logic is_float_reg(input logic [REG_ADDR_W-1:0] addr);
    return addr >= REG_ADDR_W'(REG_FLOAT_BASE);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant from req and rr_ptr, pointer moves past the winner.
// Zero latency grant; a requester waits at most NREQ-1 cycles while others are served.
module rr_arbiter #(
  parameter int NREQ = 3,
  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_vld
);

  logic [IDXW-1:0] rr_ptr;
  logic [IDXW-1:0] sel;
  int              idx;

  // Scan starting at rr_ptr, wrapping at NREQ; the first valid requester wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = IDXW'(idx);
      if (!gnt_vld && req[sel]) begin
        gnt_vld  = 1'b1;
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (gnt_vld) begin
      rr_ptr <= (gnt_idx == IDXW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Shares the register-file write port between ALU/FPU/LSU; grant in N, registered write in N+1.
// req_ready is combinational from req_valid and the rr pointer; pending never stalls requesters.
module reg_wb_arbiter
  import reg_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int XLEN = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NREQ-1:0]                      req_valid,
  input  logic [NREQ-1:0][REG_ADDR_W-1:0]      req_addr,
  input  logic [NREQ-1:0][XLEN-1:0]            req_data,
  output logic [NREQ-1:0]                      req_ready,
  input  logic                                 issue_valid,
  input  logic [REG_ADDR_W-1:0]                issue_addr,
  output logic [NUM_REGS-1:0]                  wr_enable,
  output logic [XLEN-1:0]                      wr_data,
  output logic [NUM_REGS-1:0]                  pending
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef struct packed {
    logic [NUM_REGS-1:0] en;
    logic [XLEN-1:0]     dat;
  } commit_t;

  logic [NREQ-1:0]       arb_req;
  logic [NREQ-1:0]       gnt;
  logic [IDXW-1:0]       gnt_idx;
  logic                  gnt_vld;
  logic [REG_ADDR_W-1:0] sel_addr;
  logic [XLEN-1:0]       sel_data;
  logic [NUM_REGS-1:0]   sel_onehot;
  logic [NUM_REGS-1:0]   sb_set;
  logic [NUM_REGS-1:0]   sb_clr;
  logic [NUM_REGS-1:0]   pend_nxt;
  logic [NUM_REGS-1:0]   pend_q;
  commit_t               commit_q;

  // Masking requests during reset keeps req_ready low while rst is high.
  assign arb_req = req_valid & {NREQ{~rst}};

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr_arbiter (
    .clk     (clk),
    .rst     (rst),
    .req     (arb_req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign req_ready  = gnt;
  assign sel_addr   = req_addr[gnt_idx];
  assign sel_data   = req_data[gnt_idx];
  assign sel_onehot = onehot32(sel_addr);

  // Commit register; r0 writes are accepted but decode to an empty enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_q <= '0;
    end else if (gnt_vld) begin
      commit_q.en  <= sel_onehot;
      commit_q.dat <= sel_data;
    end else begin
      commit_q.en  <= '0;
    end
  end

  assign wr_enable = commit_q.en;
  assign wr_data   = commit_q.dat;

  // Set after clear: a same-cycle issue to the same register is a newer in-flight write.
  always_comb begin
    sb_set   = issue_valid ? onehot32(issue_addr) : '0;
    sb_clr   = gnt_vld ? sel_onehot : '0;
    pend_nxt = ((pend_q & ~sb_clr) | sb_set) & ~NUM_REGS'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_nxt;
    end
  end

  assign pending = pend_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed and randomized check of reg_wb_arbiter against a queue-free behavioural model.
module tb_reg_wb_arbiter;

  localparam int NREQ = 3;
  localparam int XLEN = 32;

  logic                       clk;
  logic                       rst;
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0][4:0]       req_addr;
  logic [NREQ-1:0][XLEN-1:0]  req_data;
  logic [NREQ-1:0]            req_ready;
  logic                       issue_valid;
  logic [4:0]                 issue_addr;
  logic [31:0]                wr_enable;
  logic [XLEN-1:0]            wr_data;
  logic [31:0]                pending;

  int n_chk;
  int n_err;
  bit chk_on;

  reg_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .wr_enable   (wr_enable),
    .wr_data     (wr_data),
    .pending     (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_ptr;
  logic [31:0] m_en;
  logic [31:0] m_data;
  logic [31:0] m_pend;
  int          m_wait [NREQ];

  function automatic int winner(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int i = (p + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr  = 0;
      m_en   = 0;
      m_data = 0;
      m_pend = 0;
      for (int i = 0; i < NREQ; i++) m_wait[i] = 0;
    end else begin
      int w;
      logic [4:0] a;
      w = winner(req_valid, m_ptr);
      m_en = 0;
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && i != w) m_wait[i]++;
      end
      if (w >= 0) begin
        if (m_wait[w] >= NREQ) chk("service_bound", 64'(m_wait[w]), 64'(NREQ - 1));
        m_wait[w] = 0;
        a = req_addr[w[1:0]];
        m_data = req_data[w[1:0]];
        if (a != 0) begin
          m_en = 32'd1 << a;
          m_pend[a] = 1'b0;
        end
        m_ptr = (w + 1) % NREQ;
      end
      if (issue_valid && issue_addr != 0) m_pend[issue_addr] = 1'b1;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      int w;
      logic [NREQ-1:0] exp_rdy;
      w = rst ? -1 : winner(req_valid, m_ptr);
      exp_rdy = (w < 0) ? '0 : (NREQ'(1) << w);
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("wr_enable", 64'(wr_enable), 64'(m_en));
      chk("wr_data", 64'(wr_data), 64'(m_data));
      chk("pending", 64'(pending), 64'(m_pend));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
    req_valid[i] = v;
    req_addr[i]  = a;
    req_data[i]  = d;
  endtask

  logic [NREQ-1:0] acc;
  logic [NREQ-1:0] rr_rdy [4];
  logic [31:0]     rr_en  [4];

  initial begin
    n_chk = 0;
    n_err = 0;
    chk_on = 1'b0;
    rst = 1'b0;
    req_valid = '0;
    req_addr = '0;
    req_data = '0;
    issue_valid = 1'b0;
    issue_addr = '0;
    #2 rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_on = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_wr_enable", 64'(wr_enable), 64'h0);
    chk("rst_wr_data", 64'(wr_data), 64'h0);
    chk("rst_pending", 64'(pending), 64'h0);
    chk("rst_ready", 64'(req_ready), 64'h0);
    tick();

    // single ALU write to r5
    drv(0, 1'b1, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    chk("single_ready", 64'(req_ready), 64'h1);
    tick();
    drv(0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("single_en", 64'(wr_enable), 64'h20);
    chk("single_data", 64'(wr_data), 64'hDEADBEEF);
    tick();
    @(negedge clk);
    chk("single_en_off", 64'(wr_enable), 64'h0);

    // r0 write from LSU, pointer is at FPU so LSU wins and pointer wraps to ALU
    drv(2, 1'b1, 5'd0, 32'h12345678);
    @(negedge clk);
    chk("r0_ready", 64'(req_ready), 64'h4);
    tick();
    drv(2, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("r0_en", 64'(wr_enable), 64'h0);
    tick();

    // round robin with all three valid
    rr_rdy = '{3'b001, 3'b010, 3'b100, 3'b001};
    rr_en  = '{32'h2, 32'h20000, 32'h8, 32'h2};
    drv(0, 1'b1, 5'd1, 32'hA0);
    drv(1, 1'b1, 5'd17, 32'hB1);
    drv(2, 1'b1, 5'd3, 32'hC2);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c < 4) chk("rr_ready", 64'(req_ready), 64'(rr_rdy[c]));
      if (c > 0) chk("rr_en", 64'(wr_enable), 64'(rr_en[c-1]));
      tick();
    end
    req_valid = '0;
    tick();

    // scoreboard set then clear by FPU write
    issue_valid = 1'b1;
    issue_addr = 5'd9;
    tick();
    issue_valid = 1'b0;
    @(negedge clk);
    chk("sb_set", 64'(pending), 64'h200);
    drv(1, 1'b1, 5'd9, 32'h99);
    @(negedge clk);
    chk("sb_fpu_ready", 64'(req_ready), 64'h2);
    tick();
    drv(1, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("sb_clear", 64'(pending), 64'h0);
    chk("sb_clear_en", 64'(wr_enable), 64'h200);

    // set/clear collision on r9
    issue_valid = 1'b1;
    issue_addr = 5'd9;
    tick();
    drv(0, 1'b1, 5'd9, 32'h55);
    tick();
    issue_valid = 1'b0;
    drv(0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("coll_pending", 64'(pending), 64'h200);
    chk("coll_en", 64'(wr_enable), 64'h200);
    tick();

    // reset mid-stream with a commit in flight
    drv(0, 1'b1, 5'd7, 32'h77);
    issue_valid = 1'b1;
    issue_addr = 5'd4;
    tick();
    drv(0, 1'b0, 5'd0, 32'h0);
    issue_valid = 1'b0;
    drv(1, 1'b1, 5'd2, 32'h22);
    @(negedge clk);
    chk("pre_rst_en", 64'(wr_enable), 64'h80);
    chk("pre_rst_pending", 64'(pending), 64'h210);
    chk("pre_rst_ready", 64'(req_ready), 64'h2);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_en", 64'(wr_enable), 64'h0);
    chk("async_rst_pending", 64'(pending), 64'h0);
    chk("async_rst_ready", 64'(req_ready), 64'h0);
    tick();
    drv(0, 1'b1, 5'd1, 32'h101);
    drv(1, 1'b1, 5'd17, 32'h111);
    drv(2, 1'b1, 5'd3, 32'h121);
    @(negedge clk);
    chk("in_rst_en", 64'(wr_enable), 64'h0);
    chk("in_rst_ready", 64'(req_ready), 64'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("post_rst_en", 64'(wr_enable), 64'h2);
    chk("post_rst_data", 64'(wr_data), 64'h101);
    tick();

    // randomized traffic; requesters hold their write until accepted
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 99) < 60);
          req_addr[i]  = 5'($urandom_range(0, 31));
          req_data[i]  = $urandom;
        end
      end
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_addr  = 5'($urandom_range(0, 31));
    end

    req_valid = '0;
    issue_valid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("drain_en", 64'(wr_enable), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Write-back arbiter and scoreboard in front of the 32-entry register file (r0 hard-wired zero, r1–r15 integer, r16–r31 = f0–f15 float). It shares the single register-file write port between the ALU, FPU and load/store unit:
- Round-robin grant.
- Registered one-hot `enable` vector plus broadcast write data.
- A pending-write scoreboard that the issue stage reads for RAW/WAW hazard stalls.

## Interface
Parameters:
- `NREQ`, 3: number of write-back requesters; index 0 = ALU, 1 = FPU, 2 = LSU.
- `XLEN`, 32: data width.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid`  in  NREQ: requester i holds a write-back.
- `req_addr`  in  NREQ×5: destination register per requester.
- `req_data`  in  NREQ×XLEN: write data per requester.
- `req_ready`  out  NREQ: requester i's write accepted this cycle (combinational).
- `issue_valid`  in  1: issue stage dispatches an instruction with a destination.
- `issue_addr`  in  5: destination register of the issued instruction.
- `wr_enable`  out  32: registered one-hot enable to the register file; bit 0 is always 0.
- `wr_data`  out  XLEN: registered write data, broadcast to every register input.
- `pending`  out  32: scoreboard; bit r = write to r outstanding; bit 0 is always 0.

## Operation
- Handshake: a transfer occurs when `req_valid[i] && req_ready[i]`.
  - At most one `req_ready` is high per cycle.
  - `req_ready` never rises without `req_valid`.
  - A requester holds valid/addr/data stable until accepted.
- Arbitration is round-robin over valid requesters, starting at pointer `rr_ptr`.
  - After a grant, `rr_ptr` = winner + 1 mod NREQ.
  - With no grant, `rr_ptr` is unchanged.
- Commit: the granted addr/data is registered. Next cycle, `wr_enable` = one-hot(addr) and `wr_data` = data.
  - With no grant, `wr_enable` = 0 and `wr_data` holds its previous value.
- Writes to r0 are accepted (ready high, pointer advances) but produce `wr_enable` = 0 and touch no scoreboard bit.
- Scoreboard:
  - `issue_valid` with addr≠0 sets `pending[addr]` at the edge.
  - A grant with addr≠0 clears `pending[addr]` at the same edge as the `wr_enable` register is loaded.
  - Same-cycle set and clear of the same bit: set wins (a newer in-flight write exists).
  - Clearing a bit that is already 0 is legal and leaves it 0.
- The block does not stall requesters based on `pending`; hazard stalling is the issue stage's job.

## Timing
- Reset (async assert, any cycle) forces `wr_enable` = 0, `wr_data` = 0, `pending` = 0, `rr_ptr` = 0. `req_ready` is then forced to 0 while `rst` is high.
- Reset mid-operation discards the registered commit; no write reaches the register file.
- Latency:
  - Grant in cycle N → `wr_enable` high in cycle N+1 → register file captures at the end of N+1.
  - The `pending` bit clears visibly in cycle N+1, the same cycle the write is presented.
  - Issue stage therefore sees the clear one cycle before the register value is readable. It must add one cycle or use a bypass path.
- Throughput: one write per cycle sustained. Each requester is guaranteed service within NREQ cycles of asserting valid.
- `req_ready` is combinational from `req_valid` and `rr_ptr` only, never from the address or data inputs.

## Structure
- Shared package `reg_pkg`:
  - `NUM_REGS` = 32, `REG_ADDR_W` = 5, `REG_FLOAT_BASE` = 16.
  - Enum `wb_src_t` {WB_ALU, WB_FPU, WB_LSU}.
  - Function `onehot32(addr)` returning 0 for addr 0.
- Sub-module `rr_arbiter`, parameterized on NREQ. It owns `rr_ptr` and produces a one-hot grant plus the encoded winner index.
- Top level owns:
  - the commit register (`wr_enable`/`wr_data`);
  - the 32-bit scoreboard, with bit 0 tied to 0.

## Test plan
- Reset: assert `rst` mid-stream with ALU valid → `wr_enable` = 0, `pending` = 0, `req_ready` = 0 immediately. After release, the first grant goes to ALU.
- Single write: ALU valid, addr 5, data 0xDEADBEEF in cycle N → `req_ready[0]` high in N; `wr_enable` = 0x20 and `wr_data` = 0xDEADBEEF in N+1; `wr_enable` = 0 in N+2.
- Round robin: all three valid continuously, addrs 1/17/3 → grant order ALU, FPU, LSU, ALU. `wr_enable` sequence 0x2, 0x20000, 0x8, 0x2.
- r0 write: LSU valid, addr 0 → `req_ready[2]` high; `wr_enable` stays 0 next cycle; `rr_ptr` advances to 0.
- Scoreboard: issue addr 9 → `pending` = 0x200. Then FPU write to 9 → `pending` = 0 in the same cycle `wr_enable` = 0x200.
- Set/clear collision: `issue_addr` = 9 and ALU write to 9 in the same cycle, with bit 9 previously set → `pending[9]` stays 1 and `wr_enable` = 0x200.
